// File: rtl/wash_pkg.sv
// Shared encodings and default durations for the washing-machine program sequencer.
package wash_pkg;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_FILL    = 3'd1;
    localparam logic [2:0] PH_AGITATE = 3'd2;
    localparam logic [2:0] PH_DRAIN   = 3'd3;
    localparam logic [2:0] PH_SPIN    = 3'd4;
    localparam logic [2:0] PH_PAUSE   = 3'd5;
    localparam logic [2:0] PH_DONE    = 3'd6;
    localparam logic [2:0] PH_FAULT   = 3'd7;

    typedef enum logic [2:0] {
        StIdle    = PH_IDLE,
        StFill    = PH_FILL,
        StAgitate = PH_AGITATE,
        StDrain   = PH_DRAIN,
        StSpin    = PH_SPIN,
        StPause   = PH_PAUSE,
        StDone    = PH_DONE,
        StFault   = PH_FAULT
    } phase_e;

    localparam logic [1:0] MODE_FULL  = 2'd0;
    localparam logic [1:0] MODE_WASH  = 2'd1;
    localparam logic [1:0] MODE_RINSE = 2'd2;
    localparam logic [1:0] MODE_SPIN  = 2'd3;

    localparam int unsigned FILL_MAX_S_DEF  = 120;
    localparam int unsigned DRAIN_MAX_S_DEF = 90;
    localparam int unsigned WASH_S_DEF      = 600;
    localparam int unsigned RINSE_S_DEF     = 240;
    localparam int unsigned RINSE_N_DEF     = 2;
    localparam int unsigned SPIN_S_DEF      = 180;
    localparam int unsigned ALARM_S_DEF     = 10;
    localparam int unsigned TW_DEF          = 10;

endpackage

// File: rtl/wash_program_sequencer_if.sv
// Sensor/command inputs and actuator/status outputs of the wash program sequencer.
interface wash_program_sequencer_if #(
    parameter int unsigned TW = 10
);
    logic          sec_tick;
    logic          start;
    logic          emergency;
    logic [1:0]    mode_sel;
    logic          level_full;
    logic          level_empty;
    logic          inlet;
    logic          drain;
    logic          motor_en;
    logic          motor_spin;
    logic [2:0]    phase;
    logic [TW-1:0] remain;
    logic          busy;
    logic          alarm;
    logic          fault;

    modport master (
        output sec_tick, start, emergency, mode_sel, level_full, level_empty,
        input  inlet, drain, motor_en, motor_spin, phase, remain, busy, alarm, fault
    );

    modport slave (
        input  sec_tick, start, emergency, mode_sel, level_full, level_empty,
        output inlet, drain, motor_en, motor_spin, phase, remain, busy, alarm, fault
    );
endinterface

// File: rtl/wash_sec_timer.sv
// Seconds timer: loadable, counts up or down on sec_tick, saturates at both ends.
module wash_sec_timer #(
    parameter int unsigned TW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          count_up,
    input  logic          freeze,
    output logic [TW-1:0] value,
    output logic          zero
);
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && !freeze) begin
            if (count_up) begin
                if (cnt_q != '1) cnt_d = cnt_q + TW'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);
endmodule

// File: rtl/wash_program_sequencer.sv
// Washing-machine program controller: fill/wash/drain/rinse/spin sequencing with
// emergency pause, sensor timeouts and end-of-cycle alarm.
module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned FILL_MAX_S  = FILL_MAX_S_DEF,
    parameter int unsigned DRAIN_MAX_S = DRAIN_MAX_S_DEF,
    parameter int unsigned WASH_S      = WASH_S_DEF,
    parameter int unsigned RINSE_S     = RINSE_S_DEF,
    parameter int unsigned RINSE_N     = RINSE_N_DEF,
    parameter int unsigned SPIN_S      = SPIN_S_DEF,
    parameter int unsigned ALARM_S     = ALARM_S_DEF,
    parameter int unsigned TW          = TW_DEF
) (
    input logic                    clk,
    input logic                    rst,
    wash_program_sequencer_if.slave bus
);
    if (FILL_MAX_S >= (1 << TW) || DRAIN_MAX_S >= (1 << TW) || WASH_S >= (1 << TW) ||
        RINSE_S >= (1 << TW) || SPIN_S >= (1 << TW) || ALARM_S >= (1 << TW) ||
        RINSE_N < 1 || RINSE_N > 3) begin : g_param_check
        $error("wash_program_sequencer: parameter out of range for TW");
    end

    phase_e        state_q, state_d, saved_q, saved_d;
    logic [1:0]    mode_q, mode_d, rinse_q, rinse_d;
    logic          wash_q, wash_d, start_q;
    logic          start_pe, active;
    logic          t_load, t_up, t_freeze, t_zero;
    logic [TW-1:0] t_val, timer;

    assign start_pe = bus.start & ~start_q;
    assign active   = (state_q == StFill) || (state_q == StAgitate) ||
                      (state_q == StDrain) || (state_q == StSpin);

    wash_sec_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (bus.sec_tick),
        .load     (t_load),
        .load_val (t_val),
        .count_up (t_up),
        .freeze   (t_freeze),
        .value    (timer),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            saved_q <= StIdle;
            mode_q  <= MODE_FULL;
            rinse_q <= 2'd0;
            wash_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            mode_q  <= mode_d;
            rinse_q <= rinse_d;
            wash_q  <= wash_d;
            start_q <= bus.start;
        end
    end

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        mode_d   = mode_q;
        rinse_d  = rinse_q;
        wash_d   = wash_q;
        t_load   = 1'b0;
        t_val    = '0;
        t_up     = (state_q == StFill) || (state_q == StDrain);
        t_freeze = 1'b0;
        // Emergency pre-empts every other transition and freezes the timer in place.
        if (active && !bus.emergency) begin
            state_d  = StPause;
            saved_d  = state_q;
            t_freeze = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    t_freeze = 1'b1;
                    if (start_pe && bus.emergency) begin
                        mode_d  = bus.mode_sel;
                        rinse_d = (bus.mode_sel == MODE_RINSE) ? 2'd1 : 2'd0;
                        wash_d  = (bus.mode_sel == MODE_FULL) || (bus.mode_sel == MODE_WASH);
                        t_load  = 1'b1;
                        state_d = (bus.mode_sel == MODE_SPIN) ? StDrain : StFill;
                    end
                end
                StFill: begin
                    if (bus.level_full) begin
                        state_d = StAgitate;
                        t_load  = 1'b1;
                        t_val   = wash_q ? TW'(WASH_S) : TW'(RINSE_S);
                    end else if (timer == TW'(FILL_MAX_S)) begin
                        state_d = StFault;
                        t_load  = 1'b1;
                    end
                end
                StAgitate: begin
                    if (t_zero || (bus.sec_tick && timer == TW'(1))) begin
                        state_d = StDrain;
                        t_load  = 1'b1;
                    end
                end
                StDrain: begin
                    if (bus.level_empty) begin
                        t_load = 1'b1;
                        if (mode_q == MODE_WASH && wash_q) begin
                            state_d = StDone;
                            t_val   = TW'(ALARM_S);
                        end else if (mode_q == MODE_SPIN || rinse_q == 2'(RINSE_N)) begin
                            state_d = StSpin;
                            t_val   = TW'(SPIN_S);
                        end else begin
                            // rinse_q counts rinses started, so mode 2 begins at 1
                            rinse_d = rinse_q + 2'd1;
                            wash_d  = 1'b0;
                            state_d = StFill;
                        end
                    end else if (timer == TW'(DRAIN_MAX_S)) begin
                        state_d = StFault;
                        t_load  = 1'b1;
                    end
                end
                StSpin: begin
                    if (t_zero || (bus.sec_tick && timer == TW'(1))) begin
                        state_d = StDone;
                        t_load  = 1'b1;
                        t_val   = TW'(ALARM_S);
                    end
                end
                StPause: begin
                    t_freeze = 1'b1;
                    if (start_pe && bus.emergency) state_d = saved_q;
                end
                StDone: begin
                    if (start_pe || t_zero || (bus.sec_tick && timer == TW'(1))) begin
                        state_d = StIdle;
                        t_load  = 1'b1;
                    end
                end
                StFault: t_freeze = 1'b1;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.inlet      = (state_q == StFill) && bus.emergency;
        bus.drain      = ((state_q == StDrain) || (state_q == StSpin)) && bus.emergency;
        bus.motor_en   = ((state_q == StAgitate) || (state_q == StSpin)) && bus.emergency;
        bus.motor_spin = (state_q == StSpin) && bus.emergency;
        bus.phase      = (active && !bus.emergency) ? PH_PAUSE : 3'(state_q);
        bus.remain     = (active || state_q == StPause) ? timer : '0;
        bus.busy       = active || (state_q == StPause);
        bus.alarm      = (state_q == StDone) || (state_q == StFault);
        bus.fault      = (state_q == StFault);
    end
endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer with a plan-queue reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_wash_program_sequencer;
    localparam int unsigned TW        = 10;
    localparam int unsigned FILL_MAX  = 8;
    localparam int unsigned DRAIN_MAX = 6;
    localparam int unsigned WASH      = 5;
    localparam int unsigned RINSE     = 4;
    localparam int unsigned RINSE_N   = 2;
    localparam int unsigned SPIN      = 3;
    localparam int unsigned ALARM     = 10;

    localparam int P_IDLE = 0, P_FILL = 1, P_AGIT = 2, P_DRAIN = 3;
    localparam int P_SPIN = 4, P_PAUSE = 5, P_DONE = 6, P_FAULT = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    wash_program_sequencer_if #(.TW(TW)) bus ();

    wash_program_sequencer #(
        .FILL_MAX_S  (FILL_MAX),
        .DRAIN_MAX_S (DRAIN_MAX),
        .WASH_S      (WASH),
        .RINSE_S     (RINSE),
        .RINSE_N     (RINSE_N),
        .SPIN_S      (SPIN),
        .ALARM_S     (ALARM),
        .TW          (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of agitation durations still to run, plus a spin flag.
    int m_st = P_IDLE, m_cnt = 0, m_saved = P_IDLE;
    bit m_do_spin = 1'b0, m_start_q = 1'b0;
    int plan[$];

    function automatic bit m_active();
        return m_st == P_FILL || m_st == P_AGIT || m_st == P_DRAIN || m_st == P_SPIN;
    endfunction

    task automatic model_step(input bit pe);
        if (m_active() && !bus.emergency) begin
            m_saved = m_st;
            m_st = P_PAUSE;
            return;
        end
        case (m_st)
            P_IDLE: if (pe && bus.emergency) begin
                plan.delete();
                if (bus.mode_sel <= 2'd1) plan.push_back(WASH);
                if (bus.mode_sel == 2'd0 || bus.mode_sel == 2'd2)
                    for (int i = 0; i < RINSE_N; i++) plan.push_back(RINSE);
                m_do_spin = (bus.mode_sel != 2'd1);
                m_cnt = 0;
                m_st = (plan.size() != 0) ? P_FILL : P_DRAIN;
            end
            P_FILL: begin
                if (bus.level_full) begin m_cnt = plan.pop_front(); m_st = P_AGIT; end
                else if (m_cnt == FILL_MAX) begin m_cnt = 0; m_st = P_FAULT; end
                else if (bus.sec_tick) m_cnt++;
            end
            P_AGIT, P_SPIN: begin
                if (bus.sec_tick && m_cnt > 0) m_cnt--;
                if (m_cnt == 0) begin
                    if (m_st == P_AGIT) m_st = P_DRAIN;
                    else begin m_st = P_DONE; m_cnt = ALARM; end
                end
            end
            P_DRAIN: begin
                if (bus.level_empty) begin
                    if (plan.size() != 0) begin m_st = P_FILL; m_cnt = 0; end
                    else if (m_do_spin) begin m_st = P_SPIN; m_cnt = SPIN; end
                    else begin m_st = P_DONE; m_cnt = ALARM; end
                end else if (m_cnt == DRAIN_MAX) begin m_cnt = 0; m_st = P_FAULT; end
                else if (bus.sec_tick) m_cnt++;
            end
            P_PAUSE: if (pe && bus.emergency) m_st = m_saved;
            P_DONE: begin
                if (bus.sec_tick && m_cnt > 0) m_cnt--;
                if (pe || m_cnt == 0) begin m_st = P_IDLE; m_cnt = 0; end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_st = P_IDLE; m_cnt = 0; m_saved = P_IDLE; m_start_q = 1'b0; plan.delete();
        end else begin
            bit pe;
            pe = bus.start && !m_start_q;
            m_start_q = bus.start;
            model_step(pe);
        end
    end

    function automatic logic [TW+9:0] expected_vec();
        int eff;
        logic [TW-1:0] rem;
        eff = (m_active() && !bus.emergency) ? P_PAUSE : m_st;
        rem = (eff >= P_FILL && eff <= P_PAUSE) ? TW'(m_cnt) : '0;
        return {eff == P_FILL, eff == P_DRAIN || eff == P_SPIN, eff == P_AGIT || eff == P_SPIN,
                eff == P_SPIN, 3'(eff), rem, eff >= P_FILL && eff <= P_PAUSE,
                eff == P_DONE || eff == P_FAULT, eff == P_FAULT};
    endfunction

    initial forever begin
        logic [TW+9:0] act, exp_v;
        @(negedge clk);
        if (rst) begin
            act = {bus.inlet, bus.drain, bus.motor_en, bus.motor_spin, bus.phase, bus.remain,
                   bus.busy, bus.alarm, bus.fault};
            exp_v = expected_vec();
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL model_outputs t=%0t: got %h expected %h", $time, act, exp_v);
            end
        end
    end

    // Event counters sampled at mid-cycle, used by the literal checkpoints.
    int c_inlet_tick = 0, c_motor_tick = 0, c_alarm_tick = 0, c_spin_tick = 0;
    int c_fill_ent = 0, c_agit_ent = 0, c_inlet_cyc = 0;
    logic [2:0] prev_ph = 3'd0;
    initial forever begin
        @(negedge clk);
        if (bus.sec_tick && bus.inlet) c_inlet_tick++;
        if (bus.sec_tick && bus.motor_en && !bus.motor_spin) c_motor_tick++;
        if (bus.sec_tick && bus.alarm) c_alarm_tick++;
        if (bus.sec_tick && bus.motor_spin && bus.drain) c_spin_tick++;
        if (bus.phase == 3'd1 && prev_ph != 3'd1) c_fill_ent++;
        if (bus.phase == 3'd2 && prev_ph != 3'd2) c_agit_ent++;
        if (bus.inlet) c_inlet_cyc++;
        prev_ph = bus.phase;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            bus.sec_tick = 1'b1; step();
            bus.sec_tick = 1'b0; step(); step();
        end
    endtask

    task automatic start_pulse();
        bus.start = 1'b1; step();
        bus.start = 1'b0; step();
    endtask

    task automatic full_pulse();
        bus.level_full = 1'b1; step(); bus.level_full = 1'b0;
    endtask

    task automatic empty_pulse();
        bus.level_empty = 1'b1; step(); bus.level_empty = 1'b0;
    endtask

    task automatic tick_until(input int ph, input int limit, input string name);
        int k = 0;
        while (int'(bus.phase) != ph && k < limit) begin tick_n(1); k++; end
        chk(name, 32'(bus.phase), 32'(ph));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, m0, a0, f0, g0, s0;
        bus.sec_tick = 0; bus.start = 0; bus.emergency = 1; bus.mode_sel = 0;
        bus.level_full = 0; bus.level_empty = 0;
        step(); step();
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_outputs", 32'({bus.inlet, bus.drain, bus.motor_en, bus.motor_spin,
                                bus.busy, bus.alarm, bus.fault}), 0);
        chk("rst_remain", 32'(bus.remain), 0);
        rst = 1'b1; step();

        // Mode 1: wash only
        bus.mode_sel = 2'd1; i0 = c_inlet_tick;
        start_pulse();
        chk("m1_fill", 32'(bus.phase), 1);
        tick_n(3);
        chk("m1_fill_elapsed", 32'(bus.remain), 3);
        full_pulse();
        chk("m1_agit", 32'(bus.phase), 2);
        chk("m1_wash_load", 32'(bus.remain), WASH);
        chk("m1_inlet_ticks", 32'(c_inlet_tick - i0), 3);
        m0 = c_motor_tick;
        tick_n(5);
        chk("m1_drain", 32'(bus.phase), 3);
        chk("m1_motor_ticks", 32'(c_motor_tick - m0), 5);
        tick_n(2);
        empty_pulse();
        chk("m1_done", 32'(bus.phase), 6);
        chk("m1_alarm", 32'(bus.alarm), 1);
        a0 = c_alarm_tick;
        tick_n(9);
        chk("m1_done_hold", 32'(bus.phase), 6);
        tick_n(1);
        chk("m1_idle", 32'(bus.phase), 0);
        chk("m1_alarm_ticks", 32'(c_alarm_tick - a0), ALARM);

        // Mode 0: wash + two rinses + spin
        bus.mode_sel = 2'd0; f0 = c_fill_ent; g0 = c_agit_ent;
        start_pulse();
        for (int r = 0; r < 3; r++) begin
            tick_n(1);
            full_pulse();
            tick_until(P_DRAIN, 10, "m0_agit_to_drain");
            empty_pulse();
        end
        chk("m0_spin", 32'(bus.phase), 4);
        s0 = c_spin_tick;
        tick_n(3);
        chk("m0_done", 32'(bus.phase), 6);
        chk("m0_spin_ticks", 32'(c_spin_tick - s0), SPIN);
        chk("m0_fill_entries", 32'(c_fill_ent - f0), 3);
        chk("m0_agit_entries", 32'(c_agit_ent - g0), 3);
        start_pulse();
        chk("m0_done_start_idle", 32'(bus.phase), 0);

        // Emergency pause mid-agitation
        bus.mode_sel = 2'd1;
        start_pulse();
        tick_n(1);
        full_pulse();
        tick_n(2);
        chk("em_remain_before", 32'(bus.remain), 3);
        bus.emergency = 1'b0; #1;
        chk("em_motor_same_cycle", 32'(bus.motor_en), 0);
        chk("em_phase_same_cycle", 32'(bus.phase), 5);
        step();
        tick_n(4);
        chk("em_remain_frozen", 32'(bus.remain), 3);
        chk("em_phase_paused", 32'(bus.phase), 5);
        bus.emergency = 1'b1; step();
        chk("em_no_resume_without_start", 32'(bus.phase), 5);
        start_pulse();
        chk("em_resume_phase", 32'(bus.phase), 2);
        chk("em_resume_remain", 32'(bus.remain), 3);
        tick_n(3);
        chk("em_resume_drain", 32'(bus.phase), 3);
        empty_pulse();
        start_pulse();

        // Fill timeout
        bus.mode_sel = 2'd0;
        start_pulse();
        tick_n(FILL_MAX);
        chk("ft_phase", 32'(bus.phase), 7);
        chk("ft_flags", 32'({bus.fault, bus.alarm, bus.inlet, bus.busy}), 32'b1100);
        start_pulse();
        chk("ft_start_ignored", 32'(bus.phase), 7);
        rst = 1'b0; #1;
        chk("ft_rst_clear", 32'({bus.phase, bus.fault, bus.alarm}), 0);
        step(); rst = 1'b1; step();

        // Mode 3: spin only
        bus.mode_sel = 2'd3; i0 = c_inlet_cyc;
        start_pulse();
        chk("m3_drain", 32'(bus.phase), 3);
        tick_n(1);
        empty_pulse();
        chk("m3_spin", 32'({bus.phase, bus.motor_spin, bus.drain}), 32'b10011);
        chk("m3_spin_load", 32'(bus.remain), SPIN);
        tick_n(3);
        chk("m3_done", 32'(bus.phase), 6);
        chk("m3_no_inlet", 32'(c_inlet_cyc - i0), 0);
        start_pulse();

        // Asynchronous reset during spin, then restart
        start_pulse();
        empty_pulse();
        tick_n(1);
        chk("ar_spinning", 32'(bus.motor_en), 1);
        #2 rst = 1'b0; #1;
        chk("ar_outputs_drop", 32'({bus.motor_en, bus.drain, bus.phase}), 0);
        step(); rst = 1'b1; step();
        bus.mode_sel = 2'd1;
        start_pulse();
        chk("ar_restart_fill", 32'({bus.phase, bus.inlet}), 32'b0011);
        full_pulse();
        chk("ar_restart_agit", 32'(bus.phase), 2);
        rst = 1'b0; step(); rst = 1'b1; step();

        // Sensor beats same-cycle fill timeout; then drain timeout
        start_pulse();
        tick_n(FILL_MAX - 1);
        bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
        chk("st_at_limit", 32'(bus.remain), FILL_MAX);
        full_pulse();
        chk("st_sensor_wins", 32'(bus.phase), 2);
        tick_n(WASH);
        tick_n(DRAIN_MAX - 1);
        chk("dt_elapsed", 32'(bus.remain), DRAIN_MAX - 1);
        tick_n(1);
        chk("dt_fault", 32'(bus.phase), 7);
        rst = 1'b0; step(); rst = 1'b1; step();

        // Emergency has no effect in idle
        bus.emergency = 1'b0; step();
        chk("idle_emergency", 32'({bus.phase, bus.busy}), 0);
        bus.emergency = 1'b1; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wash_program_sequencer.md
Name: wash_program_sequencer

Overview:
- Top-level program controller for the washing machine.
- Sequences the phases fill, wash, drain, rinse and spin according to a selected program.
- Drives the inlet and drain valves, and enables and configures the motor direction controller through motor_en and motor_spin.
- Handles emergency pause and resume, sensor timeouts, and the end-of-cycle alarm.
- Counts seconds from a 1-cycle sec_tick enable on the single system clock.

Parameters:
- FILL_MAX_S, 120, maximum seconds allowed to reach level_full before FAULT
- DRAIN_MAX_S, 90, maximum seconds allowed to reach level_empty before FAULT
- WASH_S, 600, agitation seconds in the wash phase
- RINSE_S, 240, agitation seconds per rinse
- RINSE_N, 2, number of rinse repetitions (1..3)
- SPIN_S, 180, spin seconds
- ALARM_S, 10, seconds alarm stays high in DONE
- TW, 10, width of the seconds timer and of remain

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse once per second
- start  in  1  start/resume request, sampled on rising edge
- emergency  in  1  active-low emergency stop, level
- mode_sel  in  2  program: 0 full (wash+rinse+spin), 1 wash only, 2 rinse+spin, 3 spin only
- level_full  in  1  drum-full sensor
- level_empty  in  1  drum-empty sensor
- inlet  out  1  inlet valve open
- drain  out  1  drain valve open
- motor_en  out  1  motor controller run enable (agitation pattern when motor_spin=0)
- motor_spin  out  1  high-speed single-direction spin request
- phase  out  3  current state encoding
- remain  out  TW  seconds left in the current timed phase
- busy  out  1  program in progress (any state except IDLE/DONE/FAULT)
- alarm  out  1  cycle-finished or fault alarm
- fault  out  1  sticky timeout fault

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, rinse counter 0.
- start edge detect: one register; start_pe = start & ~start_q. Acted on in the cycle start_pe is high; register outputs update the next clock.
- Phase encodings: IDLE=0, FILL=1, AGITATE=2, DRAIN=3, SPIN=4, PAUSE=5, DONE=6, FAULT=7. A sub-flag wash_not_rinse distinguishes wash from rinse agitation.
- IDLE:
  - start_pe with emergency=1 latches mode_sel. Mode 3 goes to DRAIN; modes 0/1/2 go to FILL.
  - mode_sel changes outside IDLE are ignored.
- FILL: inlet=1. Timer counts up on sec_tick.
  - level_full goes to AGITATE with the timer loaded to WASH_S (modes 0/1 first pass) or RINSE_S.
  - Timer reaching FILL_MAX_S goes to FAULT.
- AGITATE: motor_en=1, motor_spin=0. Timer decrements on sec_tick; at 1→0 go to DRAIN.
- DRAIN: drain=1.
  - level_empty with mode 1 after wash goes to DONE.
  - level_empty otherwise goes to SPIN, loaded with SPIN_S, when the program's spin step is due. The spin step is due for mode 3, or once rinse count equals RINSE_N.
  - Otherwise increment the rinse count and go to FILL.
  - Timeout at DRAIN_MAX_S goes to FAULT.
- SPIN: drain=1, motor_en=1, motor_spin=1. Countdown; at 0 go to DONE.
- PAUSE:
  - Entry: emergency=0 in any busy state.
  - Entry effect: save the state and timer; the same cycle's outputs go all 0 (combinational gating of inlet/drain/motor_en/motor_spin by emergency); the timer is frozen.
  - Exit: start_pe with emergency=1 restores the saved state and timer unchanged.
  - Emergency in IDLE/DONE/FAULT has no effect.
- DONE: alarm=1 for ALARM_S ticks, then IDLE. start_pe in DONE goes to IDLE immediately.
- FAULT: all actuators 0; alarm=1 and fault=1 held until rst.
- Simultaneous events:
  - emergency low beats any same-cycle transition.
  - A sensor edge and a timeout in the same cycle: the sensor wins.
- remain: the countdown value in AGITATE/SPIN, the elapsed count in FILL/DRAIN, 0 elsewhere.
- Width: the timer saturates at 0 and never wraps. All parameters must be < 2^TW; an elaboration check enforces this.
- Reset mid-operation: immediate return to IDLE with valves closed, asynchronously.

Decomposition:
- Package wash_pkg holds:
  - phase encodings (localparams)
  - mode_sel encodings
  - default durations
- One sub-module: wash_sec_timer (load, count-up/count-down select, freeze, sec_tick enable, zero flag).

Test Plan:
- Mode 1, WASH_S=5, FILL_MAX_S=8: start, level_full after 3 ticks → inlet 3 s, motor_en 5 ticks, drain until level_empty, alarm high 10 ticks, then IDLE.
- Mode 0, RINSE_N=2: count FILL entries = 3 and AGITATE entries = 3; SPIN asserts motor_spin=1 with drain=1 for SPIN_S ticks.
- Emergency low mid-AGITATE at remain=3: same cycle motor_en=0, phase=5; remain stays 3 across 4 ticks; start_pe → AGITATE resumes at 3.
- Never assert level_full: after FILL_MAX_S ticks phase=7, fault=alarm=1; start ignored; rst clears everything.
- Mode 3: start → DRAIN directly, no inlet pulse; level_empty → SPIN → DONE.
- Assert rst during SPIN: motor_en/drain drop without a clock edge; phase=0; restart works normally.
